fft_stage_ctrl: RTL

//  Sequencer for the in-place radix-2 DIF FFT over an N-point complex sample RAM.
//  Per butterfly it issues the read-address pair, the twiddle exponent and the trivial

---
 rtl/fft_stage_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_stage_ctrl.sv
// Butterfly sequencer for an in-place radix-2 DIF FFT: issues read-address pairs,
// twiddle exponents and trivial twiddle coefficients, then the delayed write-back pairs.
module fft_stage_ctrl #(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                    CLK,
  input  logic                    RST_X,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [LOG2N-1:0]        STAGE,
  output logic                    RD_EN,
  output logic [LOG2N-1:0]        RD_ADDR_A,
  output logic [LOG2N-1:0]        RD_ADDR_B,
  output logic [LOG2N-2:0]        TW_IDX,
  output logic                    TW_TRIV,
  output logic signed [1:0]       W_RE,
  output logic signed [1:0]       W_IM,
  output logic                    WR_EN,
  output logic [LOG2N-1:0]        WR_ADDR_A,
  output logic [LOG2N-1:0]        WR_ADDR_B
);

  localparam int BW = LOG2N - 1;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DW = 2 * LOG2N + 1;

  localparam logic [BW-1:0]    B_LAST = {BW{1'b1}};
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
  localparam logic [CW-1:0]    C_LAST = CW'(PIPE_LAT - 1);
  localparam logic [BW-1:0]    K_QTR  = BW'(1 << (LOG2N - 2));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LOG2N-1:0]     s_q, s_d;
  logic [BW-1:0]        b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [LOG2N-1:0]     stage_q, stage_d;
  logic                 rd_en_q, rd_en_d;
  logic [LOG2N-1:0]     rd_a_q, rd_a_d;
  logic [LOG2N-1:0]     rd_b_q, rd_b_d;
  logic [BW-1:0]        tw_q, tw_d;
  logic                 triv_q, triv_d;
  logic signed [1:0]    w_re_q, w_re_d;
  logic signed [1:0]    w_im_q, w_im_d;

  logic [DW-1:0]        dly_q [PIPE_LAT];
  logic [DW-1:0]        dly_d [PIPE_LAT];

  // Butterfly index bits below the half-span position select j; bits above select the group g.
  function automatic logic [BW-1:0] lo_mask(input logic [LOG2N-1:0] s);
    return {BW{1'b1}} >> s;
  endfunction

  // A = g*2h + j: insert a zero bit into b at the half-span position.
  function automatic logic [LOG2N-1:0] addr_top(input logic [LOG2N-1:0] s,
                                                input logic [BW-1:0]    b);
    logic [BW-1:0] m;
    m = lo_mask(s);
    return {b & ~m, 1'b0} | {1'b0, b & m};
  endfunction

  function automatic logic [LOG2N-1:0] addr_bot(input logic [LOG2N-1:0] s,
                                                input logic [BW-1:0]    b);
    return addr_top(s, b) | ({1'b0, lo_mask(s)} + 1'b1);
  endfunction

  function automatic logic [BW-1:0] tw_exp(input logic [LOG2N-1:0] s,
                                           input logic [BW-1:0]    b);
    return (b & lo_mask(s)) << s;
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      RUN: begin
        if (b_q == B_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      DRAIN: begin
        // Hold off the next stage until every write-back of this one has landed.
        if (cnt_q == C_LAST) begin
          if (s_q == S_LAST) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            s_d     = s_q + 1'b1;
            b_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue stage: outputs are registered from the next-state decision.
  always_comb begin
    rd_en_d = (state_d == RUN);
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == FIN);
    stage_d = s_d;
    rd_a_d  = '0;
    rd_b_d  = '0;
    tw_d    = '0;
    if (rd_en_d) begin
      rd_a_d = addr_top(s_d, b_d);
      rd_b_d = addr_bot(s_d, b_d);
      tw_d   = tw_exp(s_d, b_d);
    end
    triv_d = rd_en_d && ((tw_d == '0) || (tw_d == K_QTR));
    w_re_d = (rd_en_d && (tw_d == '0))  ? 2'sb01 : 2'sb00;
    w_im_d = (rd_en_d && (tw_d == K_QTR)) ? 2'sb11 : 2'sb00;
  end

  // Write-back stage: shift register matching the butterfly datapath latency.
  always_comb begin
    dly_d[0] = {rd_en_q, rd_a_q, rd_b_q};
    for (int i = 1; i < PIPE_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      triv_q  <= 1'b0;
      w_re_q  <= '0;
      w_im_q  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stage_q <= stage_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      triv_q  <= triv_d;
      w_re_q  <= w_re_d;
      w_im_q  <= w_im_d;
      dly_q   <= dly_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign STAGE     = stage_q;
  assign RD_EN     = rd_en_q;
  assign RD_ADDR_A = rd_a_q;
  assign RD_ADDR_B = rd_b_q;
  assign TW_IDX    = tw_q;
  assign TW_TRIV   = triv_q;
  assign W_RE      = w_re_q;
  assign W_IM      = w_im_q;
  assign {WR_EN, WR_ADDR_A, WR_ADDR_B} = dly_q[PIPE_LAT-1];

endmodule
